// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Brief    : Shared elevator-controller constants.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;
  localparam int NUM_FLOORS = 4;
endpackage
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : debounce_cell
// Brief    : Single-button synchronizer, stability counter, level and edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_cell #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  localparam int                 c_CNT_W    = $clog2(STABLE_SAMPLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;
  logic               r_press;
  logic               r_release;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (tick) begin
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
          // Pulses are registered alongside the level so they coincide with it.
          r_level   <= ~r_level;
          r_cnt     <= '0;
          r_press   <= ~r_level;
          r_release <= r_level;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Debounces NUM_BTNS floor-call buttons, sampled on clk_divided rises.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer
  import elevator_pkg::*;
#(
  parameter int NUM_BTNS       = NUM_FLOORS,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_divided,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);
  logic r_div_prev;
  logic r_tick;

  // div_prev resets high so a divider already high at release is not a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_prev <= 1'b1;
      r_tick     <= 1'b0;
    end else begin
      r_div_prev <= clk_divided;
      r_tick     <= clk_divided & ~r_div_prev;
    end
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
    debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .tick       (r_tick),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Self-checking bench with a cycle model feeding a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;
  localparam int NB = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_divided;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  button_debouncer #(.NUM_BTNS(NB), .STABLE_SAMPLES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_divided(clk_divided),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial forever #42 clk = ~clk;

  typedef struct {
    logic [NB-1:0] lvl;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [NB-1:0] m_sync1, m_sync2, m_level, m_press, m_rel;
  int            m_cnt [NB];
  logic          m_div_prev, m_tick;

  int   div_phase = 0;
  logic div_last  = 1'b1;
  int   rises     = 0;
  int   press_cnt [NB];
  int   rel_cnt   [NB];
  int   hit_1001  = 0;
  int   other_pr  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end
    hit_1001 = 0;
    other_pr = 0;
  endtask

  task automatic model_update();
    if (rst) begin
      m_sync1 = '0; m_sync2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
      m_div_prev = 1'b1;
      m_tick     = 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        m_press[b] = 1'b0;
        m_rel[b]   = 1'b0;
        if (m_tick) begin
          if (m_sync2[b] == m_level[b]) m_cnt[b] = 0;
          else if (m_cnt[b] == SS - 1) begin
            m_level[b] = ~m_level[b];
            m_cnt[b]   = 0;
            if (m_level[b]) m_press[b] = 1'b1;
            else            m_rel[b]   = 1'b1;
          end else m_cnt[b]++;
        end
      end
      m_tick     = clk_divided & ~m_div_prev;
      m_div_prev = clk_divided;
      m_sync2    = m_sync1;
      m_sync1    = btn_raw;
    end
  endtask

  // One clk cycle: drive divider at negedge, model at posedge, compare at negedge.
  task automatic step();
    exp_t e;
    clk_divided = (div_phase < 3);
    if (clk_divided && !div_last) rises++;
    div_last  = clk_divided;
    div_phase = (div_phase + 1) % 6;
    @(posedge clk);
    model_update();
    e.lvl = m_level; e.pr = m_press; e.rl = m_rel;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("level",   32'(btn_level),   32'(e.lvl));
      chk("press",   32'(btn_press),   32'(e.pr));
      chk("release", 32'(btn_release), 32'(e.rl));
    end
    chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] += int'(btn_press[b]);
      rel_cnt[b]   += int'(btn_release[b]);
    end
    if (btn_press == 4'b1001) hit_1001++;
    else if (btn_press != '0) other_pr++;
  endtask

  initial begin
    rst         = 1'b1;
    btn_raw     = 4'b1111;
    clk_divided = 1'b1;
    clear_counts();
    @(negedge clk);

    // Reset with all buttons high and divider high; release mid-high phase.
    step();
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_press", 32'(btn_press), 32'd0);
    step();
    rst   = 1'b0;
    rises = 0;
    for (int i = 0; i < 60 && btn_level != 4'b1111; i++) step();
    chk("reset_ticks_to_level", rises, 3);
    chk("reset_level_all", 32'(btn_level), 32'hf);

    btn_raw = 4'b0000;
    clear_counts();
    repeat (30) step();
    for (int b = 0; b < NB; b++) chk("drop_all_release", rel_cnt[b], 1);

    // Clean press on button 0.
    clear_counts();
    btn_raw[0] = 1'b1;
    repeat (30) step();
    chk("clean_press0", press_cnt[0], 1);
    chk("clean_level0", 32'(btn_level), 32'h1);
    chk("clean_other", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Bounce on button 1: toggle every 4 clk for 40 clk, then hold.
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (4) step();
    end
    chk("bounce_no_press", press_cnt[1], 0);
    btn_raw[1] = 1'b1;
    repeat (60) step();
    chk("bounce_one_press", press_cnt[1], 1);
    chk("bounce_level1", 32'(btn_level[1]), 32'd1);

    // Release on button 2.
    btn_raw[2] = 1'b1;
    repeat (30) step();
    chk("rel_setup_level2", 32'(btn_level[2]), 32'd1);
    clear_counts();
    btn_raw[2] = 1'b0;
    repeat (30) step();
    chk("rel_count2", rel_cnt[2], 1);
    chk("rel_no_press2", press_cnt[2], 0);
    chk("rel_level2", 32'(btn_level[2]), 32'd0);

    // Simultaneous press on buttons 0 and 3.
    btn_raw[0] = 1'b0;
    repeat (30) step();
    clear_counts();
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    repeat (30) step();
    chk("simul_1001_cycles", hit_1001, 1);
    chk("simul_other_press", other_pr, 0);

    // Reset in the middle of a count on button 0.
    btn_raw[0] = 1'b0;
    repeat (30) step();
    btn_raw[0] = 1'b1;
    rises = 0;
    for (int i = 0; i < 30 && rises < 2; i++) step();
    step();
    step();
    chk("midcount_level0", 32'(btn_level[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_level", 32'(btn_level), 32'd0);
    chk("async_press", 32'(btn_press | btn_release), 32'd0);
    step();
    step();
    rst   = 1'b0;
    rises = 0;
    for (int i = 0; i < 60 && !btn_level[0]; i++) step();
    chk("midcount_ticks_after_reset", rises, 3);
    chk("midcount_level_after", 32'(btn_level[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Downstream consumer of the clock divider's `clk_divided` output.
- Debounces NUM_BTNS raw floor-call push-buttons. It samples them once per rising edge of `clk_divided`, which it uses as a sample-enable and never as a clock.
- Outputs per button: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Feeds the elevator request queue. Runs entirely in the 12 MHz `clk` domain.

Parameters:
- NUM_BTNS, 4: number of buttons, one per floor call; must be ≥1.
- STABLE_SAMPLES, 3: consecutive sample ticks a new input value must persist before the debounced level changes; must be ≥1.

Ports:
- clk  input  1  system clock (12 MHz).
- rst  input  1  asynchronous, active-high reset.
- clk_divided  input  1  divided clock from clk_divider; its rising edge defines the sample tick.
- btn_raw  input  NUM_BTNS  raw asynchronous button inputs, active-high.
- btn_level  output  NUM_BTNS  debounced button state.
- btn_press  output  NUM_BTNS  one-clk pulse on a debounced 0→1 transition.
- btn_release  output  NUM_BTNS  one-clk pulse on a debounced 1→0 transition.

Behaviour:
- Reset values:
  - btn_level, btn_press, btn_release = 0.
  - Synchronizer flops = 0.
  - All counters = 0.
  - div_prev = 1, so no spurious tick occurs if clk_divided is already high at reset release.
- Synchronizer: btn_raw passes through a 2-flop synchronizer per bit, giving btn_sync. clk_divided is already clk-synchronous and is not re-synchronized.
- Tick generation:
  - tick = clk_divided & ~div_prev, registered compare; div_prev <= clk_divided every cycle.
  - tick is high for exactly one clk cycle per clk_divided rising edge.
- Per-button cell: counter cnt of width $clog2(STABLE_SAMPLES+1), plus registered level. Evaluated only on a tick cycle:
  - btn_sync == level: cnt <= 0.
  - btn_sync != level and cnt == STABLE_SAMPLES-1: level <= ~level, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Non-tick cycles: cnt and level hold. btn_sync changes between ticks are ignored.
- Edge pulses:
  - btn_press[i] is high in the same cycle btn_level[i] first reads 1, i.e. registered together with level, not derived one cycle later.
  - btn_release[i] behaves the same way for the transition to 0.
  - Press and release for one button are never high together.
- Latency:
  - A raw change settles into btn_sync 2 clk later.
  - The level then flips on the STABLE_SAMPLES-th consecutive tick at which btn_sync differs from level.
  - The press or release pulse asserts in that cycle.
- Bounce: any tick with btn_sync equal to level resets cnt, so stability must be strictly consecutive.
- Independence: buttons are independent. Simultaneous transitions on several buttons produce pulses in the same cycle.
- STABLE_SAMPLES == 1: level follows btn_sync on every tick.
- Reset mid-operation: everything clears immediately (async). After release, a full STABLE_SAMPLES ticks are required again.
- A held button does not retrigger btn_press.

Decomposition:
- Shared package/include elevator_pkg holds NUM_FLOORS (default 4). button_debouncer's NUM_BTNS defaults from it in the top level.
- One sub-module, debounce_cell: single-bit synchronizer, counter, level and edge pulses, with parameter STABLE_SAMPLES.
- The top-level module owns tick generation and a generate loop of NUM_BTNS cells.

Test Plan:
- Common setup: clk 12 MHz; bench drives clk_divided as a square wave, 3 clk high / 3 clk low (tick every 6 clk); NUM_BTNS=4, STABLE_SAMPLES=3.
- Reset: rst=1 with btn_raw=4'b1111 and clk_divided=1, release rst mid-high phase → no tick in the first cycle. All outputs stay 0 until 3 ticks after reset.
- Clean press: btn_raw[0] 0→1 and held → btn_level[0] rises on the 3rd tick after btn_sync[0]=1. btn_press[0] is high exactly 1 cycle, in the same cycle. No other bits change.
- Bounce:
  - Toggle btn_raw[1] every 4 clk for 40 clk, then hold at 1.
  - No btn_press[1] during the bounce window.
  - Exactly one btn_press[1], on the 3rd consecutive tick with btn_sync[1]=1.
- Release: with btn_level[2]=1, drop btn_raw[2] → btn_level[2] falls after 3 ticks. One btn_release[2] pulse, no btn_press[2].
- Simultaneous: btn_raw[0] and btn_raw[3] rise in the same cycle → btn_press = 4'b1001 for exactly one cycle.
- Reset mid-count: hold btn_raw[0]=1 through 2 ticks, pulse rst, keep btn_raw[0]=1 → btn_level[0] rises only after 3 further ticks post-reset.
